// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the multi-cycle controller and the datapath/memory it steers.
//   master : controller side (consumes opcode/flags/mem_ready, drives controls)
//   slave  : datapath side (drives opcode/flags/mem_ready, consumes controls)
// Signals:
//   op[5:0]           opcode field of the instruction register
//   gtz               ALU "operand A > 0" flag, meaningful in BRANCH
//   mem_ready         memory completes the current access this cycle
//   state[3:0]        controller state encoding
//   pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
//   mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0]
//                     datapath mux selects and write enables
//   instr_done        one-cycle pulse in the last cycle of an instruction
//   trap, trap_cause  sticky halt indication and its first cause
//   retired[RET_W-1:0] retired-instruction counter
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if #(
    parameter int unsigned RET_W = 32
);
    logic [5:0]       op;
    logic             gtz;
    logic             mem_ready;
    logic [3:0]       state;
    logic             pc_en;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic             instr_done;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [RET_W-1:0] retired;

    modport master (
        input  op, gtz, mem_ready,
        output state, pc_en, iord, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               instr_done, trap, trap_cause, retired
    );

    modport slave (
        output op, gtz, mem_ready,
        input  state, pc_en, iord, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               instr_done, trap, trap_cause, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle control unit for the MIPS subset add/R-type, j, addi, bgtz, lw,
// sw. Steps a shared ALU, a unified memory port and the register file through
// FETCH/DECODE/EXECUTE/MEM/WB states, with a memory ready handshake guarded by
// a wait timeout, a sticky trap state and a retired-instruction counter.
// Ports:
//   clk_i  system clock, rising-edge
//   rst_i  synchronous active-high reset
//   bus    multicycle_ctrl_if.master (opcode/flags/mem_ready in, controls out)
// Parameters:
//   WAIT_LIMIT  max consecutive not-ready cycles in a memory state (1..65535)
//   RET_W       width of the retired-instruction counter
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int unsigned WAIT_LIMIT = 255,
    parameter int unsigned RET_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    multicycle_ctrl_if.master bus
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_ALU_WB   = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_MEM_ADDR = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_MEM_WB   = 4'd7;
    localparam logic [3:0] S_MEM_WR   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // The counter holds the number of not-ready cycles already spent, so the
    // cycle that finds it at WAIT_LIMIT-1 with mem_ready low is the last one.
    localparam logic [15:0] WAIT_LAST = 16'(WAIT_LIMIT - 1);

    logic [3:0]       state_q,   state_d;
    logic [15:0]      wait_q,    wait_d;
    logic [1:0]       cause_q,   cause_d;
    logic             is_imm_q,  is_imm_d;
    logic [RET_W-1:0] retired_q, retired_d;

    logic       pc_en_s;
    logic       iord_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [1:0] pc_source_s;
    logic       done_s;

    // Next state, wait counter, trap cause and addi flag
    always_comb begin
        state_d  = state_q;
        wait_d   = 16'd0;
        cause_d  = cause_q;
        is_imm_d = is_imm_q;
        case (state_q)
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                // mem_ready takes priority over an expiring timeout
                if (bus.mem_ready) begin
                    if (state_q == S_FETCH) begin
                        state_d = S_DECODE;
                    end else if (state_q == S_MEM_RD) begin
                        state_d = S_MEM_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_DECODE: begin
                is_imm_d = (bus.op == OP_ADDI);
                case (bus.op)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BGTZ:      state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R:   state_d = S_ALU_WB;
            S_EXEC_I:   state_d = S_ALU_WB;
            S_ALU_WB:   state_d = S_FETCH;
            S_MEM_ADDR: begin
                if (bus.op == OP_SW) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_WB:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // Datapath controls decoded from the registered state plus mem_ready/gtz
    always_comb begin
        pc_en_s      = 1'b0;
        iord_s       = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;
        pc_source_s  = 2'b00;
        done_s       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                ir_write_s  = bus.mem_ready;
                pc_en_s     = bus.mem_ready;
            end
            S_DECODE: begin
                // Branch target computed early into ALUOut
                alu_src_b_s = 2'b11;
            end
            S_EXEC_R: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b10;
            end
            S_ALU_WB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = ~is_imm_q;
                done_s      = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_MEM_RD: begin
                iord_s     = 1'b1;
                mem_read_s = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                done_s       = 1'b1;
            end
            S_MEM_WR: begin
                iord_s      = 1'b1;
                mem_write_s = 1'b1;
                done_s      = bus.mem_ready;
            end
            S_BRANCH: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b11;
                pc_source_s = 2'b01;
                pc_en_s     = bus.gtz;
                done_s      = 1'b1;
            end
            S_JUMP: begin
                pc_source_s = 2'b10;
                pc_en_s     = 1'b1;
                done_s      = 1'b1;
            end
            default: begin
                // TRAP and unreachable encodings drive nothing
                pc_en_s = 1'b0;
            end
        endcase
    end

    // Retired counter next value, wrapping at all-ones
    always_comb begin
        if (done_s) begin
            retired_d = retired_q + {{(RET_W-1){1'b0}}, 1'b1};
        end else begin
            retired_d = retired_q;
        end
    end

    // State and bookkeeping registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            wait_q    <= 16'd0;
            cause_q   <= CAUSE_NONE;
            is_imm_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cause_q   <= cause_d;
            is_imm_q  <= is_imm_d;
            retired_q <= retired_d;
        end
    end

    // Strobes are held off while reset is asserted so a pending access is
    // abandoned and no write can complete during reset.
    assign bus.pc_en      = pc_en_s     & ~rst_i;
    assign bus.mem_read   = mem_read_s  & ~rst_i;
    assign bus.mem_write  = mem_write_s & ~rst_i;
    assign bus.ir_write   = ir_write_s  & ~rst_i;
    assign bus.reg_write  = reg_write_s & ~rst_i;
    assign bus.instr_done = done_s      & ~rst_i;

    assign bus.iord       = iord_s;
    assign bus.reg_dst    = reg_dst_s;
    assign bus.mem_to_reg = mem_to_reg_s;
    assign bus.alu_src_a  = alu_src_a_s;
    assign bus.alu_src_b  = alu_src_b_s;
    assign bus.alu_op     = alu_op_s;
    assign bus.pc_source  = pc_source_s;

    assign bus.state      = state_q;
    assign bus.trap       = (state_q == S_TRAP);
    assign bus.trap_cause = cause_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
module tb_multicycle_ctrl;

    localparam int unsigned WL = 4;
    localparam int unsigned RW = 4;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BGTZ = 6'b000111;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.RET_W(RW)) bus ();

    multicycle_ctrl #(.WAIT_LIMIT(WL), .RET_W(RW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Expected response of one instruction: either a completion or a trap
    typedef struct {
        bit          is_trap;
        int          cycles;
        logic [1:0]  cause;
        logic [RW-1:0] ret;
        logic [10:0] ctrl;   // {state, reg_write, reg_dst, mem_to_reg, mem_write, pc_en, pc_source}
    } exp_t;

    exp_t          expq[$];
    int            waitq[$];
    int            n_checks = 0;
    int            n_errors = 0;
    logic [RW-1:0] model_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: cycles per instruction with a memory that is always ready
    function automatic int base_latency(input logic [5:0] op);
        case (op)
            OP_J, OP_BGTZ:         return 3;
            OP_ADD, OP_ADDI, OP_SW: return 4;
            OP_LW:                 return 5;
            default:               return 0;
        endcase
    endfunction

    // Reference: controls visible in the final cycle of each instruction
    function automatic logic [10:0] done_ctrl(input logic [5:0] op, input logic g);
        case (op)
            OP_ADD:  return {4'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
            OP_ADDI: return {4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
            OP_LW:   return {4'd7,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
            OP_SW:   return {4'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
            OP_BGTZ: return {4'd9,  1'b0, 1'b0, 1'b0, 1'b0, g,    2'b01};
            OP_J:    return {4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10};
            default: return 11'd0;
        endcase
    endfunction

    // Memory responder: answers each request after the planned number of
    // not-ready cycles taken from waitq.
    int left = -1;
    always begin
        @(negedge clk);
        if (rst) begin
            left = -1;
            bus.mem_ready = 1'b0;
        end else begin
            if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
                left = -1;
            end
            if (bus.mem_read || bus.mem_write) begin
                if (left < 0) begin
                    if (waitq.size() > 0) left = waitq.pop_front();
                    else left = 0;
                end
                if (left == 0) bus.mem_ready = 1'b1;
                else left--;
            end
        end
    end

    // Monitor: per-cycle request rules plus scoreboard pops on done/trap
    int         cyc = 0;
    bit         trap_seen = 1'b0;
    logic [1:0] held_cause = 2'b00;
    always begin
        exp_t e;
        logic [3:0] exp_req;
        @(negedge clk);
        #2;
        if (rst) begin
            cyc = 0;
            trap_seen = 1'b0;
            chk("rst_strobes", {26'd0, bus.pc_en, bus.ir_write, bus.reg_write,
                                bus.mem_read, bus.mem_write, bus.instr_done}, 32'd0);
        end else if (bus.trap) begin
            if (!trap_seen) begin
                trap_seen = 1'b1;
                if (expq.size() == 0) begin
                    chk("unexpected_trap", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    held_cause = e.cause;
                    chk("trap_expected", {31'd0, e.is_trap}, 32'd1);
                    chk("trap_latency", cyc, e.cycles);
                end
            end
            chk("trap_state", {28'd0, bus.state}, 32'd11);
            chk("trap_cause", {30'd0, bus.trap_cause}, {30'd0, held_cause});
            chk("trap_strobes", {27'd0, bus.pc_en, bus.ir_write, bus.reg_write,
                                 bus.mem_read, bus.mem_write}, 32'd0);
        end else begin
            cyc++;
            case (bus.state)
                4'd0:    exp_req = {1'b1, 1'b0, 1'b0, bus.mem_ready};
                4'd6:    exp_req = 4'b1010;
                4'd8:    exp_req = 4'b0110;
                default: exp_req = 4'b0000;
            endcase
            chk("request_rule", {28'd0, bus.mem_read, bus.mem_write, bus.iord, bus.ir_write},
                {28'd0, exp_req});
            if (bus.instr_done) begin
                if (expq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("done_expected", {31'd0, e.is_trap}, 32'd0);
                    chk("latency", cyc, e.cycles);
                    chk("retired", {{(32-RW){1'b0}}, bus.retired}, {{(32-RW){1'b0}}, e.ret});
                    chk("done_ctrl", {21'd0, bus.state, bus.reg_write, bus.reg_dst,
                                      bus.mem_to_reg, bus.mem_write, bus.pc_en, bus.pc_source},
                        {21'd0, e.ctrl});
                end
                cyc = 0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_state", {28'd0, bus.state}, 32'd0);
        chk("reset_retired", {{(32-RW){1'b0}}, bus.retired}, 32'd0);
        chk("reset_trap", {29'd0, bus.trap, bus.trap_cause}, 32'd0);
        chk("reset_mem_read", {31'd0, bus.mem_read}, 32'd0);
        waitq.delete();
        model_ret = '0;
        rst = 1'b0;
    endtask

    // Issue one instruction, record its expected outcome, wait for it to end
    task automatic run_instr(input logic [5:0] op, input logic g, input int fw, input int mw);
        exp_t e;
        bit   is_mem;
        bit   legal;
        bit   ended;
        is_mem = (op == OP_LW) || (op == OP_SW);
        legal  = (base_latency(op) != 0);
        waitq.push_back(fw);
        if (is_mem) waitq.push_back(mw);
        e.ret  = model_ret;
        e.ctrl = 11'd0;
        if (!legal) begin
            e.is_trap = 1'b1;
            e.cycles  = fw + 2;
            e.cause   = 2'b01;
        end else if (is_mem && mw >= int'(WL)) begin
            e.is_trap = 1'b1;
            e.cycles  = fw + 3 + int'(WL);
            e.cause   = 2'b10;
        end else begin
            e.is_trap = 1'b0;
            e.cycles  = base_latency(op) + fw + (is_mem ? mw : 0);
            e.cause   = 2'b00;
            e.ctrl    = done_ctrl(op, g);
            model_ret = model_ret + 1'b1;
        end
        expq.push_back(e);
        bus.op  = op;
        bus.gtz = g;
        ended = 1'b0;
        for (int k = 0; k < 200 && !ended; k++) begin
            @(negedge clk);
            #3;
            if (bus.instr_done || bus.trap) ended = 1'b1;
        end
        chk("instr_wait", {31'd0, ended}, 32'd1);
    endtask

    initial begin
        logic [5:0] ops [6];
        ops[0] = OP_ADD; ops[1] = OP_ADDI; ops[2] = OP_LW;
        ops[3] = OP_SW;  ops[4] = OP_BGTZ; ops[5] = OP_J;
        rst = 1'b1;
        bus.op = 6'd0;
        bus.gtz = 1'b0;
        bus.mem_ready = 1'b0;
        model_ret = '0;

        do_reset();
        run_instr(OP_ADD, 1'b0, 0, 0);
        run_instr(OP_LW, 1'b0, 0, 3);
        run_instr(OP_BGTZ, 1'b0, 0, 0);
        run_instr(OP_BGTZ, 1'b1, 0, 0);
        run_instr(OP_ADDI, 1'b0, 1, 0);
        run_instr(OP_SW, 1'b0, 0, 3);
        run_instr(OP_LW, 1'b0, 3, 3);
        for (int i = 0; i < 16; i++) run_instr(OP_J, 1'b0, 0, 0);
        for (int i = 0; i < 60; i++) begin
            run_instr(ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        run_instr(OP_SW, 1'b0, 0, 10);
        repeat (20) @(negedge clk);
        do_reset();

        run_instr(6'b111111, 1'b0, 0, 0);
        repeat (20) @(negedge clk);
        do_reset();

        run_instr(OP_J, 1'b0, 0, 0);
        run_instr(OP_ADD, 1'b1, 2, 0);
        chk("queue_drained", expq.size(), 32'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the lab05 MIPS subset (add/R-type, j, addi, bgtz, lw, sw). It replaces single-cycle control by stepping one shared ALU, one unified memory port and the register file through FETCH/DECODE/EXECUTE/MEM/WB states. It sits between the instruction register's opcode field and the datapath mux/enable inputs. It also adds a memory ready handshake with a timeout, a sticky trap state and a retired-instruction counter.

## Interface
- WAIT_LIMIT, 255: maximum consecutive cycles a memory state may wait for mem_ready before trapping (1..65535).
- RET_W, 32: width of retired-instruction counter.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  opcode from instruction register (insc[31:26])
- gtz  in  1  ALU flag: operand A > 0 (signed), valid in BRANCH
- mem_ready  in  1  memory completes the current read/write this cycle
- state  out  4  current state encoding
- pc_en  out  1  PC register write enable
- iord  out  1  memory address select: 0 PC, 1 ALUOut
- mem_read / mem_write  out  1 each  memory request strobes, held until mem_ready
- ir_write  out  1  instruction register load
- reg_write  out  1  register file write enable
- reg_dst  out  1  write register: 1 rd (insc[15:11]), 0 rt (insc[20:16])
- mem_to_reg  out  1  write data: 1 MDR, 0 ALUOut
- alu_src_a  out  1  0 PC, 1 register A
- alu_src_b  out  2  00 register B, 01 constant 4, 10 sext(imm), 11 sext(imm)<<2
- alu_op  out  2  00 add, 10 funct-decoded, 11 bgtz compare, 01 unused
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 {PC[31:28], target, 2'b00}
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- trap  out  1  sticky, controller halted
- trap_cause  out  2  01 illegal opcode, 10 memory timeout, 00 none
- retired  out  RET_W  count of completed instructions

## Operation
- State encodings:
  - FETCH 0, DECODE 1, EXEC_R 2, ALU_WB 3, EXEC_I 4, MEM_ADDR 5
  - MEM_RD 6, MEM_WB 7, MEM_WR 8, BRANCH 9, JUMP 10, TRAP 11
  - 12–15 unreachable; if entered, go to FETCH.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. On mem_ready: ir_write=1, pc_en=1, go to DECODE. Otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Dispatch on op:
  - 000000 → EXEC_R
  - 001000 → EXEC_I
  - 100011 or 101011 → MEM_ADDR
  - 000111 → BRANCH
  - 000010 → JUMP
  - any other → TRAP, trap_cause=01
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 → ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0; instr_done → FETCH.
- EXEC_I (addi): alu_src_a=1, alu_src_b=10, alu_op=00. Next cycle: ALU_WB behaviour but with reg_dst=0. Implement with a registered is_imm flag captured in DECODE.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw → MEM_RD, sw → MEM_WR.
- MEM_RD: iord=1, mem_read=1. On mem_ready → MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; instr_done → FETCH.
- MEM_WR: iord=1, mem_write=1. On mem_ready: instr_done → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=11, pc_source=01, pc_en=gtz; instr_done → FETCH.
- JUMP: pc_source=10, pc_en=1; instr_done → FETCH.
- TRAP:
  - All strobes 0 (pc_en, ir_write, reg_write, mem_read, mem_write).
  - Remain in TRAP until rst.
  - trap_cause holds its first value.
- Timeout:
  - A wait counter clears on every state change.
  - It increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - When the count reaches WAIT_LIMIT with mem_ready still 0: go to TRAP, trap_cause=10.
  - mem_ready=1 in that same cycle wins over the timeout.
- retired increments on every instr_done. It wraps from all-ones to 0.
- Unlisted outputs in each state are 0.

## Timing
- Reset (rst=1 at an edge): state=FETCH, retired=0, trap=0, trap_cause=00, wait counter=0, is_imm=0.
  - While rst is high, every strobe output is forced to 0, including mem_read.
  - The first request appears in the first cycle after rst is sampled low.
  - Reset mid-wait abandons the pending memory access; no write completes.
- Strobes are combinational from the registered state plus mem_ready/gtz. pc_en and ir_write are qualified by mem_ready in FETCH.
- Latency with mem_ready always 1:
  - j, bgtz: 3 cycles
  - add, addi, sw: 4 cycles
  - lw: 5 cycles
- Each cycle of mem_ready=0 in a memory state adds one cycle.
- Request rule: mem_read/mem_write stay asserted with a stable iord from entering the state through the cycle where mem_ready=1. They drop the next cycle.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.

## Test plan
- Reset then mem_ready=1 constantly, op=000000: state sequence 0,1,2,3,0. reg_write and reg_dst are high in cycle 4 only. retired=1 after 4 cycles.
- lw (op=100011) with mem_ready low for 3 cycles in MEM_RD: total 8 cycles. mem_read and iord=1 stay high throughout MEM_RD. mem_to_reg=1 and reg_dst=0 in MEM_WB.
- bgtz with gtz=0, then repeated with gtz=1: pc_en=0 in BRANCH, then pc_en=1 with pc_source=01. Each takes 3 cycles.
- op=111111: TRAP reached in cycle 3 with trap_cause=01. Strobes stay 0 for 20 more cycles. rst returns state to 0.
- WAIT_LIMIT=4, sw with mem_ready held 0: TRAP with trap_cause=10 after 4 wait cycles in MEM_WR. Repeat with mem_ready=1 on the 4th wait cycle: completes normally.
- RET_W=4, 16 back-to-back j instructions: retired wraps to 0. instr_done pulses every 3rd cycle.
